// File: rtl/regfile_pkg.sv
// Shared types and constants for the integer register file and its writeback path.
package regfile_pkg;

  localparam int XLEN      = 64;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xdata_t;

  localparam reg_idx_t X0 = '0;

  // x0 is hardwired to zero, so it can never be pending.
  function automatic logic reg_pending(input logic [NREG-1:0] mask, input reg_idx_t idx);
    return (idx != X0) && mask[idx];
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after the
// pointer, searching upward with wrap. The pointer register lives in the caller.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gnt_idx
);

  logic w_found;
  int   w_pos;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_pos     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = (int'(i_ptr) + k) % NUM_REQ;
      if (!w_found && i_req[w_pos]) begin
        w_found          = 1'b1;
        o_gnt[w_pos]     = 1'b1;
        o_gnt_idx        = IDX_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for the 32x64 register file: round-robin sharing of the
// single write port plus a pending-destination scoreboard for issue stalls.
module regfile_wb_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 64
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    issue_valid,
  input  regfile_pkg::reg_idx_t                   issue_rd,
  input  regfile_pkg::reg_idx_t                   issue_rs1,
  input  regfile_pkg::reg_idx_t                   issue_rs2,
  output logic                                    issue_stall,
  input  logic [NUM_REQ-1:0]                      wb_valid,
  input  logic [NUM_REQ*regfile_pkg::REG_IDX_W-1:0] wb_rd,
  input  logic [NUM_REQ*XLEN-1:0]                 wb_data,
  output logic [NUM_REQ-1:0]                      wb_ready,
  output logic                                    wrt_high_enable,
  output regfile_pkg::reg_idx_t                   destn_reg,
  output logic [XLEN-1:0]                         destn_data,
  output logic [regfile_pkg::NREG-1:0]            busy_mask
);

  import regfile_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_xfer;
  reg_idx_t           w_win_rd;
  logic [XLEN-1:0]    w_win_data;
  logic               w_stall;
  logic               w_issue_acc;
  logic [NREG-1:0]    w_busy_nxt;

  logic [IDX_W-1:0]   r_rr_ptr;
  logic               r_wr_en_p1;
  reg_idx_t           r_wr_rd_p1;
  logic [XLEN-1:0]    r_wr_data_p1;
  logic [NREG-1:0]    r_busy;

  // ---- stage p0: arbitration and winner select (combinational) ----
  assign w_req = wb_valid & {NUM_REQ{reset}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req     (w_req),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  always_comb begin
    w_xfer     = |w_gnt;
    w_win_rd   = wb_rd[int'(w_gnt_idx)*REG_IDX_W +: REG_IDX_W];
    w_win_data = wb_data[int'(w_gnt_idx)*XLEN +: XLEN];
  end

  always_comb begin
    w_stall = !reset ||
              (issue_valid && (reg_pending(r_busy, issue_rs1) ||
                               reg_pending(r_busy, issue_rs2) ||
                               reg_pending(r_busy, issue_rd)));
    w_issue_acc = issue_valid && !w_stall;
  end

  // Clear first so a same-cycle set of the same index wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wr_en_p1) w_busy_nxt[r_wr_rd_p1] = 1'b0;
    if (w_issue_acc && (issue_rd != X0)) w_busy_nxt[issue_rd] = 1'b1;
  end

  // ---- stage p1: register-file write port and scoreboard ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rr_ptr     <= '0;
      r_wr_en_p1   <= 1'b0;
      r_wr_rd_p1   <= X0;
      r_wr_data_p1 <= '0;
      r_busy       <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_xfer) begin
        r_rr_ptr   <= (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + 1'b1;
        r_wr_en_p1 <= (w_win_rd != X0);
        if (w_win_rd != X0) begin
          r_wr_rd_p1   <= w_win_rd;
          r_wr_data_p1 <= w_win_data;
        end
      end else begin
        r_wr_en_p1 <= 1'b0;
      end
    end
  end

  assign wb_ready        = w_gnt;
  assign issue_stall     = w_stall;
  assign wrt_high_enable = r_wr_en_p1;
  assign destn_reg       = r_wr_rd_p1;
  assign destn_data      = r_wr_data_p1;
  assign busy_mask       = r_busy;

endmodule
